// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the slice-serial 74181-style ALU.
//                - state_e    : sequencer state encoding
//                - width_ok   : legality check for the datapath width
//                - slice_fn   : one 4-bit 74181 slice (active-high data,
//                               active-low carry in/out), returns
//                               {carry_out_n, f[3:0]}
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Datapath is processed in 4-bit steps, so the width must tile exactly.
    function automatic bit width_ok(input int width);
        return (width >= 4) && ((width % 4) == 0);
    endfunction

    // 74181 slice, active-high data convention.
    // Arithmetic mode: every function is expressed as x + y + carry, where
    // x and y are the pre-combined operand terms from the datasheet table
    // ("minus 1" terms become an all-ones addend). The carry pins are
    // active-low, so cin_n=0 adds one and cout_n=0 signals a carry out.
    // Logic mode: the carry chain is not involved and cout_n is held high.
    function automatic logic [4:0] slice_fn(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [3:0] s,
        input logic       m,
        input logic       cin_n
    );
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] lf;
        logic [4:0] sum;

        x = 4'h0;
        y = 4'h0;
        case (s)
            4'h0: begin x = a;        y = 4'h0;     end  // A
            4'h1: begin x = a | b;    y = 4'h0;     end  // A + B (OR)
            4'h2: begin x = a | ~b;   y = 4'h0;     end  // A + ~B (OR)
            4'h3: begin x = 4'hF;     y = 4'h0;     end  // minus 1
            4'h4: begin x = a;        y = a & ~b;   end  // A plus A&~B
            4'h5: begin x = a | b;    y = a & ~b;   end  // (A|B) plus A&~B
            4'h6: begin x = a;        y = ~b;       end  // A minus B minus 1
            4'h7: begin x = a & ~b;   y = 4'hF;     end  // A&~B minus 1
            4'h8: begin x = a;        y = a & b;    end  // A plus A&B
            4'h9: begin x = a;        y = b;        end  // A plus B
            4'hA: begin x = a | ~b;   y = a & b;    end  // (A|~B) plus A&B
            4'hB: begin x = a & b;    y = 4'hF;     end  // A&B minus 1
            4'hC: begin x = a;        y = a;        end  // A plus A
            4'hD: begin x = a | b;    y = a;        end  // (A|B) plus A
            4'hE: begin x = a | ~b;   y = a;        end  // (A|~B) plus A
            default: begin x = a;     y = 4'hF;     end  // A minus 1
        endcase
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, ~cin_n};

        case (s)
            4'h0: lf = ~a;
            4'h1: lf = ~(a | b);
            4'h2: lf = ~a & b;
            4'h3: lf = 4'h0;
            4'h4: lf = ~(a & b);
            4'h5: lf = ~b;
            4'h6: lf = a ^ b;
            4'h7: lf = a & ~b;
            4'h8: lf = ~a | b;
            4'h9: lf = ~(a ^ b);
            4'hA: lf = b;
            4'hB: lf = a & b;
            4'hC: lf = 4'hF;
            4'hD: lf = a | ~b;
            4'hE: lf = a | b;
            default: lf = a;
        endcase

        if (m) begin
            return {1'b1, lf};
        end
        return {~sum[4], sum[3:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_slice4.sv
`default_nettype none
// ============================================================================
//  Module      : alu_slice4
//  Description : Combinational 4-bit 74181-style ALU slice. The top level
//                owns a single instance and steps it across the operand.
//  Ports       : i_a, i_b   4-bit operand slices
//                i_s        function select (74181 encoding)
//                i_m        1 = logic, 0 = arithmetic
//                i_cin_n    active-low carry in
//                o_f        4-bit result slice
//                o_cout_n   active-low carry out (1 in logic mode)
//  Revision    : 1.0  initial release
// ============================================================================
module alu_slice4
    import alu_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [3:0] i_s,
    input  logic       i_m,
    input  logic       i_cin_n,
    output logic [3:0] o_f,
    output logic       o_cout_n
);

    logic [4:0] w_res;

    assign w_res    = slice_fn(i_a, i_b, i_s, i_m, i_cin_n);
    assign o_f      = w_res[3:0];
    assign o_cout_n = w_res[4];

endmodule
`default_nettype wire

// File: rtl/slice_serial_alu.sv
`default_nettype none
// ============================================================================
//  Module      : slice_serial_alu
//  Description : WIDTH-bit 74181-compatible ALU that evaluates one 4-bit
//                slice per clock through a single shared slice, LSB first,
//                rippling the carry through a register. The result, carry
//                out and zero flag are published together on the final
//                slice edge, so partial results never appear on F.
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                start      begin an operation (sampled when busy=0)
//                A, B       WIDTH-bit operands
//                S, M, Cn   function select, mode (1=logic), active-low cin
//                F          registered result
//                Cn_out     active-low carry out of the MSB slice
//                zero       F == 0
//                busy       operation in progress
//                done       one-cycle pulse: F/Cn_out/zero just updated
//  Revision    : 1.0  initial release
// ============================================================================
module slice_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             Cn,
    output logic [WIDTH-1:0] F,
    output logic             Cn_out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NSLICE - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("slice_serial_alu: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e           r_state;
    logic [WIDTH-1:0] r_a;        // latched operands, shifted right one
    logic [WIDTH-1:0] r_b;        // slice per step so bits [3:0] are current
    logic [3:0]       r_s;
    logic             r_m;
    logic             r_carry_n;  // active-low carry into the current slice
    logic [CNT_W-1:0] r_cnt;      // index of the slice being computed
    logic [WIDTH-1:0] r_res;      // slices assembled so far (internal only)

    logic [3:0]       w_slice_f;
    logic             w_cout_n;
    logic [WIDTH-1:0] w_res_next;
    logic             w_accept;

    alu_slice4 u_slice (
        .i_a      (r_a[3:0]),
        .i_b      (r_b[3:0]),
        .i_s      (r_s),
        .i_m      (r_m),
        .i_cin_n  (r_carry_n),
        .o_f      (w_slice_f),
        .o_cout_n (w_cout_n)
    );

    // New start is honoured in IDLE and in the DONE cycle (back-to-back).
    assign w_accept = start && (r_state != ST_RUN);

    // Partial result with the current slice merged into its nibble; on the
    // final step this is the complete word published on F.
    always_comb begin
        w_res_next = r_res;
        for (int k = 0; k < NSLICE; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_res_next[4*k +: 4] = w_slice_f;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= 4'h0;
            r_m       <= 1'b0;
            r_carry_n <= 1'b0;
            r_cnt     <= '0;
            r_res     <= '0;
            F         <= '0;
            Cn_out    <= 1'b1;
            zero      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_state   <= ST_RUN;
                r_a       <= A;
                r_b       <= B;
                r_s       <= S;
                r_m       <= M;
                r_carry_n <= Cn;
                r_cnt     <= '0;
                r_res     <= '0;
                busy      <= 1'b1;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        r_a       <= r_a >> 4;
                        r_b       <= r_b >> 4;
                        r_carry_n <= w_cout_n;
                        r_res     <= w_res_next;
                        r_cnt     <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_cnt_last) begin
                            F       <= w_res_next;
                            Cn_out  <= w_cout_n;
                            zero    <= ~|w_res_next;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
